// File: rtl/ifetch_queue_if.sv
// Instruction-memory request/response bundle between the fetch queue (master) and instruction memory (slave).
interface ifetch_queue_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: credit-limited word fetches, in-order response matching, DEPTH-entry prefetch queue, branch flush.
// Optional macro IFQ_BYPASS_EN forwards an undropped response straight to decode while the queue is empty.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           PCSrcE,
  input  logic [31:0]    PCTarget,
  input  logic           stallD,
  ifetch_queue_if.master imem,
  output logic           validD,
  output logic [31:0]    InstD,
  output logic [31:0]    PCD,
  output logic [31:0]    PCPlus4D
);
  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] PTR_INC = AW'(1);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  logic [31:0]   fetchPc_r;
  logic [31:0]   rspPc_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] inflight_r;
  logic [CW-1:0] drop_r;
  logic [AW-1:0] rdPtr_r;
  logic [AW-1:0] wrPtr_r;
  logic [31:0]   instMem_r [DEPTH];
  logic [31:0]   pcMem_r   [DEPTH];

  logic [CW-1:0] credSum_s;
  logic [31:0]   target_s;
  logic          reqFire_s;
  logic          rspKeep_s;
  logic          headValid_s;
  logic          bypassHit_s;
  logic          popFire_s;
  logic          popFifo_s;
  logic          pushFire_s;

  // Queued entries plus outstanding fetches may never exceed DEPTH, so a response always finds room.
  assign credSum_s           = count_r + inflight_r;
  assign target_s            = {PCTarget[31:2], 2'b00};
  assign imem.imem_req_valid = !rst && !PCSrcE && (credSum_s < DEPTH_C);
  assign imem.imem_req_addr  = fetchPc_r;
  assign reqFire_s           = imem.imem_req_valid && imem.imem_req_ready;
  assign rspKeep_s           = imem.imem_rsp_valid && (drop_r == ZERO_C);
  assign headValid_s         = (count_r != ZERO_C);

`ifdef IFQ_BYPASS_EN
  assign bypassHit_s = !headValid_s && rspKeep_s && !PCSrcE;
`else
  assign bypassHit_s = 1'b0;
`endif

  // A redirect cancels any pop; a bypassed word taken by decode is never written into the queue.
  assign popFire_s  = validD && !stallD && !PCSrcE;
  assign popFifo_s  = popFire_s && headValid_s;
  assign pushFire_s = rspKeep_s && !PCSrcE && !(bypassHit_s && popFire_s);

`ifdef IFQ_BYPASS_EN
  // Decode view: queue head first, then the live response when the queue is empty.
  always_comb begin
    if (headValid_s) begin
      validD = 1'b1;
      InstD  = instMem_r[rdPtr_r];
      PCD    = pcMem_r[rdPtr_r];
    end else if (bypassHit_s) begin
      validD = 1'b1;
      InstD  = imem.imem_rsp_data;
      PCD    = rspPc_r;
    end else begin
      validD = 1'b0;
      InstD  = NOP;
      PCD    = 32'h0000_0000;
    end
    PCPlus4D = PCD + 32'd4;
  end
`else
  // Decode view: queue head only, NOP with PCD=0 while the queue is empty.
  always_comb begin
    if (headValid_s) begin
      validD = 1'b1;
      InstD  = instMem_r[rdPtr_r];
      PCD    = pcMem_r[rdPtr_r];
    end else begin
      validD = 1'b0;
      InstD  = NOP;
      PCD    = 32'h0000_0000;
    end
    PCPlus4D = PCD + 32'd4;
  end
`endif

  // Queue storage; contents are only meaningful between rdPtr and wrPtr, so no reset is needed.
  always_ff @(posedge clk) begin
    if (pushFire_s) begin
      instMem_r[wrPtr_r] <= imem.imem_rsp_data;
      pcMem_r[wrPtr_r]   <= rspPc_r;
    end else begin
      instMem_r[wrPtr_r] <= instMem_r[wrPtr_r];
      pcMem_r[wrPtr_r]   <= pcMem_r[wrPtr_r];
    end
  end

  // Outstanding-fetch counter: every response retires one fetch, whether kept or dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_r <= ZERO_C;
    end else begin
      case ({reqFire_s, imem.imem_rsp_valid})
        2'b10:   inflight_r <= inflight_r + ONE_C;
        2'b01:   inflight_r <= inflight_r - ONE_C;
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // PC tracking, stale-response accounting and queue pointers; redirect overrides everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetchPc_r <= RESET_PC;
      rspPc_r   <= RESET_PC;
      count_r   <= ZERO_C;
      drop_r    <= ZERO_C;
      rdPtr_r   <= {AW{1'b0}};
      wrPtr_r   <= {AW{1'b0}};
    end else if (PCSrcE) begin
      fetchPc_r <= target_s;
      rspPc_r   <= target_s;
      count_r   <= ZERO_C;
      rdPtr_r   <= {AW{1'b0}};
      wrPtr_r   <= {AW{1'b0}};
      // Every fetch still outstanding after this cycle belongs to the abandoned path.
      drop_r    <= imem.imem_rsp_valid ? (inflight_r - ONE_C) : inflight_r;
    end else begin
      fetchPc_r <= reqFire_s ? (fetchPc_r + 32'd4) : fetchPc_r;
      rspPc_r   <= rspKeep_s ? (rspPc_r + 32'd4) : rspPc_r;
      drop_r    <= (imem.imem_rsp_valid && (drop_r != ZERO_C)) ? (drop_r - ONE_C) : drop_r;
      wrPtr_r   <= pushFire_s ? (wrPtr_r + PTR_INC) : wrPtr_r;
      rdPtr_r   <= popFifo_s ? (rdPtr_r + PTR_INC) : rdPtr_r;
      case ({pushFire_s, popFifo_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue: an in-order memory with random latency plus an epoch/queue reference model.
module tb_ifetch_queue;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrcE;
  logic [31:0] PCTarget;
  logic        stallD;
  logic        validD;
  logic [31:0] InstD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;

  ifetch_queue_if imem ();

  ifetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .PCSrcE   (PCSrcE),
    .PCTarget (PCTarget),
    .stallD   (stallD),
    .imem     (imem),
    .validD   (validD),
    .InstD    (InstD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D)
  );

  always #5 clk = ~clk;

  req_t        memQ[$];
  logic [31:0] fifoPc[$];
  logic [31:0] modelPc;
  int          epoch;
  int          cyc;
  int          lastDue;
  int          checks;
  int          fails;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive inputs at negedge, compare against the model, then advance the model to the post-edge state.
  task automatic doCycle(input bit rstIn, input bit stallIn, input bit readyIn,
                         input bit redirIn, input logic [31:0] tgt, input int lat);
    bit          rspV, keep, expReq, bypass, expValid, pop, accept;
    logic [31:0] headPc, rspAddr;
    int          due;
    @(negedge clk);
    rst                 = rstIn;
    stallD              = stallIn;
    PCSrcE              = redirIn && !rstIn;
    PCTarget            = tgt;
    imem.imem_req_ready = readyIn;
    rspV    = !rstIn && (memQ.size() > 0) && (memQ[0].due <= cyc);
    rspAddr = rspV ? memQ[0].addr : 32'h0000_0000;
    imem.imem_rsp_valid = rspV;
    imem.imem_rsp_data  = rspV ? memWord(rspAddr) : 32'hDEAD_BEEF;
    keep   = rspV && !PCSrcE && (memQ[0].epoch == epoch);
    expReq = !rstIn && !PCSrcE && ((memQ.size() + fifoPc.size()) < DEPTH);
    bypass = 1'b0;
`ifdef IFQ_BYPASS_EN
    bypass = keep && (fifoPc.size() == 0);
`endif
    expValid = (fifoPc.size() > 0) || bypass;
    headPc   = (fifoPc.size() > 0) ? fifoPc[0] : (bypass ? rspAddr : 32'h0000_0000);
    #2;
    checkVal("req_valid", 32'(imem.imem_req_valid), 32'(expReq));
    if (expReq) checkVal("req_addr", imem.imem_req_addr, modelPc);
    if (!rstIn) begin
      checkVal("validD", 32'(validD), 32'(expValid));
      checkVal("InstD", InstD, expValid ? memWord(headPc) : NOP);
      checkVal("PCD", PCD, expValid ? headPc : 32'h0000_0000);
      checkVal("PCPlus4D", PCPlus4D, expValid ? (headPc + 32'd4) : 32'h0000_0004);
    end
    accept = expReq && readyIn;
    pop    = expValid && !stallIn && !PCSrcE;
    if (rstIn) begin
      memQ.delete();
      fifoPc.delete();
      modelPc = RESET_PC;
      lastDue = cyc;
    end else begin
      if (rspV) void'(memQ.pop_front());
      if (PCSrcE) begin
        fifoPc.delete();
        epoch++;
        modelPc = {tgt[31:2], 2'b00};
      end else begin
        if (pop && (fifoPc.size() > 0)) void'(fifoPc.pop_front());
        if (keep && !(bypass && pop)) fifoPc.push_back(rspAddr);
      end
      if (accept) begin
        due = cyc + lat;
        if (due <= lastDue) due = lastDue + 1;
        lastDue = due;
        memQ.push_back('{addr: modelPc, epoch: epoch, due: due});
        modelPc = modelPc + 32'd4;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    rst                 = 1'b1;
    PCSrcE              = 1'b0;
    PCTarget            = 32'h0000_0000;
    stallD              = 1'b0;
    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = 32'h0000_0000;
    modelPc = RESET_PC;
    epoch   = 0;
    cyc     = 0;
    lastDue = 0;
    checks  = 0;
    fails   = 0;

    // Reset, then a streaming run at latency 1 with no stalls.
    repeat (2) doCycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1);
    repeat (12) doCycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1);
    // Decode stalled long enough to exhaust the credits, then released.
    repeat (10) doCycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1);
    repeat (10) doCycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1);
    // Latency 3 with a redirect to an unaligned target while fetches are in flight.
    repeat (4) doCycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 3);
    doCycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0203, 3);
    repeat (12) doCycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 3);
    // Back-to-back redirects, the first coinciding with responses.
    repeat (3) doCycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1);
    doCycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 2);
    doCycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 2);
    repeat (12) doCycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2);
    // Address wrap across 2^32.
    doCycle(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF4, 1);
    repeat (12) doCycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1);
    // Fill the queue under stall, then reset mid-stream.
    repeat (6) doCycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1);
    doCycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1);
    repeat (10) doCycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1);
    // Random traffic: stalls, backpressure, latencies 1..5, redirects, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      doCycle($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 70,
              $urandom_range(0, 99) < 6, tgt, int'($urandom_range(1, 5)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
